// File: rtl/regbank_pkg.sv
// Shared constants and FSM encoding for the parametrised register bank.
package regbank_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reservation and
// cleared by the matching write or by the clear sweep.
module regbank_scoreboard import regbank_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_set_en,
  input  logic [ADDR_WIDTH-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  input  logic                  i_sweep_en,
  input  logic [ADDR_WIDTH-1:0] i_sweep_addr,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [ADDR_WIDTH-1:0] i_addr2,
  output logic                  o_pend1,
  output logic                  o_pend2
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0] r_pend;

  // A reservation outranks a write to the same register: the new producer wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend[REG_ZERO] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_sweep_en && i_sweep_addr == ADDR_WIDTH'(i))
          r_pend[i] <= 1'b0;
        else if (i_set_en && i_set_addr == ADDR_WIDTH'(i))
          r_pend[i] <= 1'b1;
        else if (i_clr_en && i_clr_addr == ADDR_WIDTH'(i))
          r_pend[i] <= 1'b0;
      end
    end
  end

  assign o_pend1 = r_pend[i_addr1];
  assign o_pend2 = r_pend[i_addr2];

endmodule

// File: rtl/register_bank_param.sv
// Parametrised register bank: two combinational reads, one write, hazard
// scoreboard and a clear sweep. Optional same-cycle forwarding: REGBANK_BYPASS_EN.
//
// state    | meaning
// ST_IDLE  | normal read/write/reserve operation
// ST_CLEAR | sweeping registers 1..NUM_REGS-1 to zero, strobes ignored
module register_bank_param import regbank_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  reserveEnable,
  input  logic [ADDR_WIDTH-1:0] reserveAddr,
  input  logic                  clearReq,
  output logic [DATA_WIDTH-1:0] outReg1,
  output logic [DATA_WIDTH-1:0] outReg2,
  output logic                  pending1,
  output logic                  pending2,
  output logic                  busy,
  output logic                  clearDone
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_clear_done;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_busy;
  logic                  w_sweep_last;
  logic                  w_wr_acc;
  logic                  w_rsv_acc;
  logic                  w_pend1;
  logic                  w_pend2;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic                  w_pend1_out;
  logic                  w_pend2_out;

  assign w_busy       = (r_state == ST_CLEAR);
  assign w_sweep_last = w_busy && (r_idx == LAST_IDX);
  assign w_wr_acc     = writeEnable && !w_busy && (rd != ZERO_ADDR);
  assign w_rsv_acc    = reserveEnable && !w_busy && (reserveAddr != ZERO_ADDR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clearReq) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_idx == LAST_IDX) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx        <= FIRST_IDX;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= w_sweep_last;
      if (w_busy) r_idx <= w_sweep_last ? FIRST_IDX : r_idx + FIRST_IDX;
    end
  end

  // A write accepted on the clearReq edge lands first and is swept later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_busy) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_acc) begin
      r_regs[rd] <= writeData;
    end
  end

  regbank_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .i_set_en    (w_rsv_acc),
    .i_set_addr  (reserveAddr),
    .i_clr_en    (w_wr_acc),
    .i_clr_addr  (rd),
    .i_sweep_en  (w_busy),
    .i_sweep_addr(r_idx),
    .i_addr1     (rs1),
    .i_addr2     (rs2),
    .o_pend1     (w_pend1),
    .o_pend2     (w_pend2)
  );

  always_comb begin
    w_rd1       = (rs1 == ZERO_ADDR) ? '0 : r_regs[rs1];
    w_rd2       = (rs2 == ZERO_ADDR) ? '0 : r_regs[rs2];
    w_pend1_out = w_pend1;
    w_pend2_out = w_pend2;
`ifdef REGBANK_BYPASS_EN
    if (w_wr_acc && rd == rs1) begin
      w_rd1       = writeData;
      w_pend1_out = 1'b0;
    end
    if (w_wr_acc && rd == rs2) begin
      w_rd2       = writeData;
      w_pend2_out = 1'b0;
    end
`endif
  end

  assign outReg1   = w_rd1;
  assign outReg2   = w_rd2;
  assign pending1  = w_pend1_out;
  assign pending2  = w_pend2_out;
  assign busy      = w_busy;
  assign clearDone = r_clear_done;

endmodule

// File: tb/tb_register_bank_param.sv
// Randomised bench for register_bank_param against a behavioural model of
// the bank contents, reservations and clear sweep.
module tb_register_bank_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0, reserveAddr = '0;
  logic          writeEnable = 1'b0, reserveEnable = 1'b0, clearReq = 1'b0;
  logic [DW-1:0] writeData = '0;
  logic [DW-1:0] outReg1, outReg2;
  logic          pending1, pending2, busy, clearDone;

  register_bank_param dut (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .writeEnable(writeEnable), .writeData(writeData),
    .reserveEnable(reserveEnable), .reserveAddr(reserveAddr),
    .clearReq(clearReq), .outReg1(outReg1), .outReg2(outReg2),
    .pending1(pending1), .pending2(pending2), .busy(busy),
    .clearDone(clearDone)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  bit            m_busy, m_done;
  int            m_pos;
  int            n_checks = 0, n_errors = 0;
  bit            obs_busy, obs_done;

  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit write_ok();
    return writeEnable && !m_busy && rd != 0;
  endfunction

  function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGBANK_BYPASS_EN
    if (write_ok() && rd == a) return writeData;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGBANK_BYPASS_EN
    if (write_ok() && rd == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_done = 1'b0;
    m_pos  = 1;
  endtask

  task automatic model_edge();
    if (m_busy) begin
      m_regs[m_pos] = '0;
      m_pend[m_pos] = 1'b0;
      if (m_pos == NR - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_pos  = 1;
      end else begin
        m_pos++;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (writeEnable && rd != 0) begin
        m_regs[rd] = writeData;
        m_pend[rd] = 1'b0;
      end
      if (reserveEnable && reserveAddr != 0) m_pend[reserveAddr] = 1'b1;
      if (clearReq) begin
        m_busy = 1'b1;
        m_pos  = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("outReg1", outReg1, exp_data(rs1));
    check("outReg2", outReg2, exp_data(rs2));
    check("pending1", DW'(pending1), DW'(exp_pend(rs1)));
    check("pending2", DW'(pending2), DW'(exp_pend(rs2)));
    check("busy", DW'(busy), DW'(m_busy));
    check("clearDone", DW'(clearDone), DW'(m_done));
  endtask

  task automatic step();
    @(negedge clock);
    obs_busy = busy;
    obs_done = clearDone;
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    writeEnable = 0; reserveEnable = 0; clearReq = 0;
  endtask

  task automatic fill_bank();
    idle_inputs();
    for (int i = 1; i < NR; i++) begin
      rd = AW'(i); writeData = $urandom | 32'h1; writeEnable = 1;
      step();
    end
    writeEnable = 0;
  endtask

  task automatic read_all();
    idle_inputs();
    for (int i = 0; i < NR; i++) begin
      rs1 = AW'(i); rs2 = AW'(NR - 1 - i);
      step();
    end
  endtask

  int busy_cycles, done_pulses;

  initial begin
    model_reset();
    rs1 = 5; rs2 = 31;
    #6;
    check_outputs();
    #2 reset = 1'b1;
    step();

    // directed writes, including discarded write to register 0
    rd = 7; writeData = 32'hDEADBEEF; writeEnable = 1; step();
    writeEnable = 0; rs1 = 7; step();
    check("rd7_readback", outReg1, 32'hDEADBEEF);
    rd = 0; writeData = 32'h1234; writeEnable = 1; rs2 = 0; step();
    writeEnable = 0; step();
    check("rd0_readback", outReg2, 32'h0);

    // reservation, reserve+write same register, then write alone
    rs1 = 9; reserveAddr = 9; reserveEnable = 1; step();
    reserveEnable = 0; step();
    check("pend9_set", DW'(pending1), 1);
    reserveEnable = 1; writeEnable = 1; rd = 9; writeData = 32'h99; step();
    reserveEnable = 0; writeEnable = 0; step();
    check("pend9_kept", DW'(pending1), 1);
    writeEnable = 1; step();
    writeEnable = 0; step();
    check("pend9_clear", DW'(pending1), 0);

    // forwarding case: old value this cycle unless bypass is built in
    rd = 12; writeData = 32'h11111111; writeEnable = 1; step();
    rs1 = 12; writeData = 32'hA5A5A5A5; step();
    writeEnable = 0; step();
    check("bypass_next", outReg1, 32'hA5A5A5A5);

    // full sweep with a write landing on the clearReq edge
    fill_bank();
    for (int i = 2; i < 6; i++) begin
      reserveAddr = AW'(i * 5); reserveEnable = 1; step();
    end
    reserveEnable = 0;
    rd = 31; writeData = 32'hC0FFEE; writeEnable = 1; clearReq = 1; step();
    idle_inputs();
    busy_cycles = 0; done_pulses = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == 5) begin
        rd = 3; writeData = 32'h77; writeEnable = 1; reserveEnable = 1;
        reserveAddr = 4; clearReq = 1;
      end else idle_inputs();
      rs1 = AW'($urandom_range(0, NR - 1)); rs2 = 3;
      step();
      if (obs_busy) busy_cycles++;
      if (obs_done) done_pulses++;
    end
    check("busy_cycles", DW'(busy_cycles), 31);
    check("done_pulses", DW'(done_pulses), 1);
    read_all();

    // randomised traffic
    for (int k = 0; k < 400; k++) begin
      rs1 = AW'($urandom); rs2 = AW'($urandom); rd = AW'($urandom);
      if ($urandom_range(0, 3) == 0) rs1 = rd;
      writeEnable = 1'($urandom); writeData = $urandom;
      reserveEnable = ($urandom_range(0, 2) == 0); reserveAddr = AW'($urandom);
      clearReq = ($urandom_range(0, 39) == 0);
      step();
    end
    idle_inputs();

    // reset asserted mid-sweep
    fill_bank();
    for (int i = 1; i < 5; i++) begin
      reserveAddr = AW'(i * 7); reserveEnable = 1; step();
    end
    reserveEnable = 0;
    clearReq = 1; step();
    clearReq = 0;
    for (int k = 0; k < 10; k++) step();
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("abort_busy", DW'(busy), 0);
    check("abort_done", DW'(clearDone), 0);
    rs1 = 20; rs2 = 28;
    #0 check_outputs();
    #1 reset = 1'b1;
    read_all();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_bank_param.md
Name: register_bank_param

Overview:
- Parametrised successor to the pipeline's integer register bank.
- Configurable data width and register count.
- Two combinational read ports and one synchronous write port; register 0 is hardwired to zero.
- Adds a pending-write scoreboard for hazard detection, and a sequential clear engine that zeroes the whole bank in one sweep.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH (localparam, minimum 2).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; all state cleared while low.
- rs1  input  ADDR_WIDTH  read address, port 1.
- rs2  input  ADDR_WIDTH  read address, port 2.
- rd  input  ADDR_WIDTH  write address.
- writeEnable  input  1  active-high write strobe.
- writeData  input  DATA_WIDTH  write data.
- reserveEnable  input  1  active-high; marks reserveAddr as having a write in flight.
- reserveAddr  input  ADDR_WIDTH  register being reserved.
- clearReq  input  1  single-cycle request to zero the bank.
- outReg1  output  DATA_WIDTH  read data, port 1.
- outReg2  output  DATA_WIDTH  read data, port 2.
- pending1  output  1  rs1 has an outstanding reservation.
- pending2  output  1  rs2 has an outstanding reservation.
- busy  output  1  clear sweep in progress.
- clearDone  output  1  one-cycle pulse when the sweep ends.

Behaviour:
- Reset (reset low, asynchronous):
  - All registers and all scoreboard bits go to 0; state IDLE; sweep index = 1.
  - busy = 0, clearDone = 0; outReg1/2 = 0, pending1/2 = 0.
- Reads:
  - Combinational, zero latency.
  - Address 0 always reads 0 with pending = 0.
- Writes:
  - Take effect at the rising edge when writeEnable = 1, busy = 0 and rd != 0.
  - Writes to rd = 0 are discarded.
- Scoreboard (one bit per register 1..NUM_REGS-1):
  - Bit set at the edge when reserveEnable = 1, busy = 0 and reserveAddr != 0.
  - Bit cleared by an accepted write to that register.
  - Simultaneous reserve and write to the same register: the bit stays set (the new producer wins).
  - Writes to registers with no reservation are legal and leave the bit at 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clearReq = 1 sampled at an edge; busy = 1 from the next cycle.
  - CLEAR: each cycle zeroes register[index] and its scoreboard bit, then index increments. Index runs 1..NUM_REGS-1, so busy stays high for NUM_REGS-1 cycles (31 at the default).
  - CLEAR -> IDLE: at the edge that zeroes index NUM_REGS-1. In the same edge clearDone is set to 1 for exactly one cycle, busy drops to 0 and index is reloaded to 1.
- Behaviour during CLEAR:
  - writeEnable, reserveEnable and clearReq are ignored (dropped, not queued).
  - Reads return current array contents: already-swept registers read 0, unswept ones keep their old values.
- clearReq while IDLE coinciding with writeEnable: the write is accepted at that same edge, then the sweep zeroes it.
- reset going low mid-sweep aborts the sweep immediately; the bank returns to the reset state with clearDone = 0.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - When writeEnable = 1, busy = 0, rd != 0 and rd == rsX, outRegX returns writeData combinationally in the same cycle and pendingX is forced to 0.
  - Same-cycle write-to-read forwarding for the pipeline decode stage.
- Undefined: reads return the stored value, so the written data is visible from the cycle after the edge.

Decomposition:
- Shared package regbank_pkg:
  - Default DATA_WIDTH/ADDR_WIDTH constants.
  - FSM state encoding (IDLE = 1'b0, CLEAR = 1'b1).
  - Register-zero index constant.
- Sub-module regbank_scoreboard:
  - NUM_REGS-bit pending vector with set/clear/sweep-clear inputs.
  - Two combinational lookup outputs.
- Storage, read muxing and the clear FSM stay in the top module.

Test Plan:
- Reset low, then high -> outReg1/outReg2 = 0 for rs1 = 5, rs2 = 31; busy = 0; pending1/2 = 0.
- Write 0xDEADBEEF to rd = 7, then read rs1 = 7 -> 0xDEADBEEF the next cycle. Write 0x1234 to rd = 0, then read rs2 = 0 -> 0.
- Reserve reg 9 -> pending1 = 1 with rs1 = 9. Reserve and write reg 9 in the same cycle -> pending stays 1. Write reg 9 alone -> pending1 = 0.
- Fill regs 1..31 with nonzero values, pulse clearReq:
  - busy high for exactly 31 cycles; clearDone pulses once as busy falls.
  - All registers read 0; a write to reg 3 mid-sweep is dropped.
- With REGBANK_BYPASS_EN: writeEnable = 1, rd = rs1 = 12, writeData = 0xA5A5A5A5 -> outReg1 = 0xA5A5A5A5 in the same cycle. Without the macro -> old value that cycle, new value the next.
- Drive reset low at sweep cycle 10 -> busy = 0, clearDone = 0; all registers and scoreboard bits are 0 after release.
